compteur_bloc_phase: RTL
========================

# compteur_bloc_phase

Parametrised, phase-aware block counter for the ASCON datapath. It is loaded with the number of associated-data (AD) blocks and plaintext (PT) blocks for one message. It counts completed blocks on a strobe and sequences IDLE → AD → PT → DONE. It reports the current block index, the current phase, a last-block flag and a done pulse to the main ASCON FSM. It replaces the single 2-bit free-running counter with bounded per-phase counts and message-level control.

## Interface
Parameters:
- CPT_W, default 4: width of block counts and index; max blocks per phase = 2^CPT_W − 1.

Ports:
- clock_i, input, 1: clock, rising edge.
- resetb_i, input, 1: reset, asynchronous, active-low.
- start_i, input, 1: latch nb_ad_i/nb_pt_i and begin a message; honoured only in IDLE or DONE.
- abort_i, input, 1: synchronous return to IDLE; highest priority.
- enable_i, input, 1: one block of the current phase has completed.
- nb_ad_i, input, CPT_W: AD block count, 0 allowed.
- nb_pt_i, input, CPT_W: PT block count, 0 allowed.
- cpt_o, output, CPT_W: index of the current block within the phase, 0-based.
- phase_o, output, 2: phase_t (IDLE=0, AD=1, PT=2, DONE=3).
- last_o, output, 1: current block is the last of the current phase.
- done_o, output, 1: single-cycle pulse on entry to DONE.
- busy_o, output, 1: phase is AD or PT.

## Operation
- **Reset** drives cpt_o=0, phase_o=IDLE, last_o=0, done_o=0, busy_o=0, and clears the latched counts to 0.
- **start_i** in IDLE or DONE:
  - latches nb_ad_q/nb_pt_q and sets cpt=0;
  - next phase is AD if nb_ad_i≠0;
  - else PT if nb_pt_i≠0;
  - else DONE, with done_o pulsing.
- **start_i in AD/PT** is ignored.
- **enable_i** acts only in AD or PT:
  - if cpt < nb−1: cpt increments.
  - if cpt = nb−1 in AD: cpt=0, phase goes to PT, or to DONE if nb_pt_q=0.
  - if cpt = nb−1 in PT: cpt=0, phase goes to DONE.
- **enable_i** is ignored in IDLE and DONE.
- **DONE** holds until start_i or abort_i.
- **abort_i** in any state: phase=IDLE, cpt=0, done_o=0, and the latched counts are kept.
- **Priority:** abort_i > start_i > enable_i. start_i and enable_i together in IDLE/DONE: start is taken and enable is dropped.
- **Width rules:**
  - comparisons are unsigned on CPT_W bits;
  - cpt never exceeds nb−1, so it never wraps;
  - nb = 2^CPT_W − 1 is legal and reaches index 2^CPT_W − 2.
- **last_o** = (phase=AD ∧ cpt=nb_ad_q−1) ∨ (phase=PT ∧ cpt=nb_pt_q−1). It is combinational from registered state.

## Timing
- All state is registered and updates on the clock_i rising edge following the qualifying input. Latency from input to cpt_o/phase_o is 1 cycle.
- done_o is registered. It is high exactly for the first cycle phase_o=DONE.
- last_o is valid in the same cycle as the cpt_o/phase_o it describes. The FSM samples it together with enable_i.
- Back-to-back enable_i (every cycle) is supported with no bubble. A phase change consumes no extra cycle.
- start_i in DONE re-arms directly. There is no intermediate IDLE cycle, and done_o drops in that cycle.
- resetb_i assertion mid-message forces the reset values immediately (asynchronous). Release is synchronised externally.

## Structure
- Add to ascon_pack:
  - typedef enum logic[1:0] phase_t {IDLE, AD, PT, DONE};
  - localparam CPT_W_DEFAULT = 4.
- One sub-module, compteur_bloc_gen: CPT_W-wide up-counter with enable, synchronous clear and async active-low reset. It is instantiated once as the index counter.
- Top level holds the phase FSM, the count latches and the last/done logic.

## Test plan
- **Reset:** assert resetb_i mid-count → cpt_o=0, phase_o=IDLE, done_o=0, busy_o=0 asynchronously.
- **Nominal:** start_i with nb_ad=2, nb_pt=3, then enable_i every cycle.
  - cpt/phase sequence AD0, AD1(last), PT0, PT1, PT2(last), DONE.
  - done_o high for 1 cycle; total of 5 enables.
- **Zero counts:**
  - nb_ad=0, nb_pt=1: start goes straight to PT0 with last_o=1; one enable → DONE.
  - nb_ad=0, nb_pt=0: start → DONE with a done_o pulse the next cycle.
- **Priority:**
  - abort_i with enable_i at AD1: phase_o=IDLE, cpt_o=0.
  - start_i with nb_ad=5 during PT: ignored, count continues.
- **Max size (CPT_W=4):** nb_ad=15, nb_pt=15 → last_o at cpt=14 in each phase; no wrap; exactly 30 enables to DONE.
- **Re-arm:** start_i in DONE with nb_ad=1, nb_pt=1 → phase_o=AD, cpt=0 next cycle; done_o=0.

Source files
------------

// File: rtl/compteur_bloc_phase_pkg.sv
// compteur_bloc_phase_pkg: phase encoding and default width for the ASCON block counter
package compteur_bloc_phase_pkg;
    typedef enum logic [1:0] {IDLE, AD, PT, DONE} phase_t;
    localparam int CPT_W_DEFAULT = 4;
endpackage

// File: rtl/compteur_bloc_phase_if.sv
// compteur_bloc_phase_if: control/status bundle between the main ASCON FSM and the block counter
interface compteur_bloc_phase_if
    import compteur_bloc_phase_pkg::*;
#(
    parameter int CPT_W = CPT_W_DEFAULT
);
    logic             start;
    logic             abort;
    logic             enable;
    logic [CPT_W-1:0] nb_ad;
    logic [CPT_W-1:0] nb_pt;
    logic [CPT_W-1:0] cpt;
    phase_t           phase;
    logic             last;
    logic             done;
    logic             busy;
    modport master (output start, abort, enable, nb_ad, nb_pt, input cpt, phase, last, done, busy);
    modport slave (input start, abort, enable, nb_ad, nb_pt, output cpt, phase, last, done, busy);
endinterface

// File: rtl/compteur_bloc_gen.sv
// compteur_bloc_gen: up-counter with enable, synchronous clear (dominant) and async active-low reset
module compteur_bloc_gen #(
    parameter int CPT_W = 4
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             clr,
    input  logic             en,
    output logic [CPT_W-1:0] q
);
    always_ff @(posedge clock_i or negedge resetb_i)
        if (!resetb_i) q <= '0;
        else q <= clr ? '0 : en ? q + CPT_W'(1) : q;
endmodule

// File: rtl/compteur_bloc_phase.sv
// compteur_bloc_phase: bounded AD/PT block counter sequencing IDLE -> AD -> PT -> DONE
module compteur_bloc_phase
    import compteur_bloc_phase_pkg::*;
#(
    parameter int CPT_W = CPT_W_DEFAULT
) (
    input  logic                  clock_i,
    input  logic                  resetb_i,
    compteur_bloc_phase_if.slave  bus
);
    logic [CPT_W-1:0] nb_ad_q, nb_pt_q, cpt, nb_m1;
    phase_t           phase_q, phase_d;
    logic             done_q, busy, take_start, step, at_end;
    assign busy       = phase_q == AD || phase_q == PT;
    assign take_start = bus.start & ~busy & ~bus.abort;
    assign step       = bus.enable & busy & ~bus.abort;
    assign nb_m1      = (phase_q == AD ? nb_ad_q : nb_pt_q) - CPT_W'(1);
    assign at_end     = cpt == nb_m1;
    // empty phases are skipped at start and at the AD->PT boundary
    always_comb
        phase_d = bus.abort ? IDLE :
                  take_start ? (bus.nb_ad != '0 ? AD : bus.nb_pt != '0 ? PT : DONE) :
                  (step && at_end) ? ((phase_q == AD && nb_pt_q != '0) ? PT : DONE) :
                  phase_q;
    compteur_bloc_gen #(.CPT_W(CPT_W)) u_cpt (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .clr      (bus.abort | take_start | (step & at_end)),
        .en       (step & ~at_end),
        .q        (cpt)
    );
    always_ff @(posedge clock_i or negedge resetb_i)
        if (!resetb_i) begin
            phase_q <= IDLE;
            nb_ad_q <= '0;
            nb_pt_q <= '0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            done_q  <= phase_d == DONE && phase_q != DONE;
            if (take_start) begin
                nb_ad_q <= bus.nb_ad;
                nb_pt_q <= bus.nb_pt;
            end
        end
    assign bus.cpt   = cpt;
    assign bus.phase = phase_q;
    assign bus.last  = busy & at_end;
    assign bus.done  = done_q;
    assign bus.busy  = busy;
endmodule
